redas_dataflow_controller: RTL and testbench

- Sequences one ReDAS roundabout PE array tile operation: accepts a command (dataflow, reduction length), steps through CONFIG/PRELOAD/COMPUTE/DRAIN, and drives the array-wide broadcast controls (data_movement_mode, calculation_pattern_mode, enable_right_angle_movement, store_stationary).
- Also paces the edge data feeder and flags feeder underrun.
- Sits between the tile scheduler and the PE grid, one instance per array.

---
 rtl/redas_ctrl_pkg.sv | 58 +++++
 rtl/redas_phase_counter.sv | 37 +++
 rtl/redas_dataflow_controller.sv | 194 +++++++++++++++++++
 tb/tb_redas_dataflow_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/redas_ctrl_pkg.sv
// Shared types, broadcast mode constants and phase-length helpers for the
// ReDAS roundabout array dataflow controller.
package redas_ctrl_pkg;

  typedef enum logic [1:0] {
    RA_WEIGHT_STATIONARY = 2'd0,
    RA_OUTPUT_STATIONARY = 2'd1,
    RA_INPUT_STATIONARY  = 2'd2
  } redas_pe_roundabout_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } ctrl_state_e;

  localparam int unsigned DMM_W = 4;
  localparam int unsigned CPM_W = 5;

  localparam logic [DMM_W-1:0] DMM_PASS   = 4'b1111;
  localparam logic [CPM_W-1:0] CPM_BYPASS = 5'b11000;

  typedef struct packed {
    logic [DMM_W-1:0] dmm;
    logic [CPM_W-1:0] cpm;
  } mode_cfg_t;

  localparam mode_cfg_t MODE_IDLE = '{dmm: DMM_PASS, cpm: CPM_BYPASS};

  // Per-dataflow broadcast mode table; the illegal encoding maps to idle.
  function automatic mode_cfg_t mode_lookup(input redas_pe_roundabout_e df);
    mode_cfg_t m;
    case (df)
      RA_WEIGHT_STATIONARY: m = '{dmm: 4'b1111, cpm: 5'b00011};
      RA_OUTPUT_STATIONARY: m = '{dmm: 4'b0101, cpm: 5'b00101};
      RA_INPUT_STATIONARY:  m = '{dmm: 4'b1010, cpm: 5'b00111};
      default:              m = MODE_IDLE;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] preload_len(input int unsigned dim);
    return 32'(dim);
  endfunction

  // Reduction length plus skew fill and flush across the array.
  function automatic logic [31:0] compute_len(input logic [31:0] k, input int unsigned dim);
    return k + 32'(2 * dim) - 32'd2;
  endfunction

  function automatic logic [31:0] drain_len(input int unsigned dim);
    return 32'(dim);
  endfunction

endpackage

// File: rtl/redas_phase_counter.sv
// Loadable down-counter that times each controller phase; saturates at zero.
module redas_phase_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/redas_dataflow_controller.sv
// Sequences one roundabout PE array tile operation and drives the array-wide
// broadcast controls plus edge-feeder pacing and underrun detection.
module redas_dataflow_controller
  import redas_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_DIM = 8,
  parameter int unsigned K_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_dataflow,
  input  logic [K_WIDTH-1:0] cmd_k_len,
  input  logic               abort,
  input  logic               feed_valid,
  output logic [DMM_W-1:0]   data_movement_mode,
  output logic [CPM_W-1:0]   calculation_pattern_mode,
  output logic               enable_right_angle_movement,
  output logic               store_stationary,
  output logic               feed_req,
  output logic               drain_valid,
  output logic               busy,
  output logic               done,
  output logic               err_underrun,
  output logic               err_cmd
);

  localparam int unsigned CNT_W = K_WIDTH + 1;

  localparam logic [CNT_W-1:0] PRELOAD_LAST = CNT_W'(preload_len(ARRAY_DIM) - 32'd1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(drain_len(ARRAY_DIM) - 32'd1);
  // While the count is at or above this, the next COMPUTE cycle still feeds.
  localparam logic [CNT_W-1:0] FEED_THR     = CNT_W'(2 * ARRAY_DIM - 1);

  ctrl_state_e          state_q, state_d;
  redas_pe_roundabout_e df_q, df_d;
  logic [K_WIDTH-1:0]   k_q, k_d;
  logic                 ill_q, ill_d;
  mode_cfg_t            mode_q, mode_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 feed_q, feed_d;
  logic                 store_q, store_d;
  logic                 drain_q, drain_d;
  logic                 err_und_q, err_und_d;
  logic                 err_cmd_q, err_cmd_d;

  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_load_val;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_zero_c;
  logic                 cmd_illegal_c;
  logic [CNT_W-1:0]     compute_last_c;

  assign cmd_illegal_c  = (cmd_dataflow == 2'd3) || (cmd_k_len == '0);
  assign compute_last_c = CNT_W'(compute_len(32'(k_q), ARRAY_DIM) - 32'd1);

  redas_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (1'b1),
    .load_val (cnt_load_val),
    .count    (cnt),
    .zero_c   (cnt_zero_c)
  );

  // Next state, command capture and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    df_d         = df_q;
    k_d          = k_q;
    ill_d        = ill_q;
    mode_d       = mode_q;
    err_cmd_d    = err_cmd_q;
    err_und_d    = err_und_q | (feed_q & ~feed_valid);
    cnt_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_CONFIG;
          df_d      = redas_pe_roundabout_e'(cmd_dataflow);
          k_d       = cmd_k_len;
          ill_d     = cmd_illegal_c;
          err_cmd_d = cmd_illegal_c;
          err_und_d = 1'b0;
          mode_d    = cmd_illegal_c ? MODE_IDLE
                                    : mode_lookup(redas_pe_roundabout_e'(cmd_dataflow));
        end
      end
      ST_CONFIG: begin
        if (ill_q) begin
          state_d = ST_DONE;
        end else if (df_q == RA_OUTPUT_STATIONARY) begin
          state_d      = ST_COMPUTE;
          cnt_load_val = compute_last_c;
        end else begin
          state_d      = ST_PRELOAD;
          cnt_load_val = PRELOAD_LAST;
        end
      end
      ST_PRELOAD: begin
        if (cnt_zero_c) begin
          state_d      = ST_COMPUTE;
          cnt_load_val = compute_last_c;
        end
      end
      ST_COMPUTE: begin
        if (cnt_zero_c) begin
          if (df_q == RA_OUTPUT_STATIONARY) begin
            state_d      = ST_DRAIN;
            cnt_load_val = DRAIN_LAST;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_zero_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end

    cnt_load = (state_d != state_q);
    if (state_d == ST_IDLE) begin
      mode_d = MODE_IDLE;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    drain_d     = (state_d == ST_DRAIN);
    store_d     = (state_d == ST_PRELOAD) ||
                  ((state_d == ST_COMPUTE) && (df_d == RA_OUTPUT_STATIONARY));
    // Entering COMPUTE always feeds (k >= 1); afterwards feed while inside the first k cycles.
    feed_d      = (state_d == ST_PRELOAD) ||
                  ((state_d == ST_COMPUTE) && ((state_q != ST_COMPUTE) || (cnt >= FEED_THR)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      df_q        <= RA_WEIGHT_STATIONARY;
      k_q         <= '0;
      ill_q       <= 1'b0;
      mode_q      <= MODE_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      feed_q      <= 1'b0;
      store_q     <= 1'b0;
      drain_q     <= 1'b0;
      err_und_q   <= 1'b0;
      err_cmd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      df_q        <= df_d;
      k_q         <= k_d;
      ill_q       <= ill_d;
      mode_q      <= mode_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      feed_q      <= feed_d;
      store_q     <= store_d;
      drain_q     <= drain_d;
      err_und_q   <= err_und_d;
      err_cmd_q   <= err_cmd_d;
    end
  end

  assign cmd_ready                   = cmd_ready_q;
  assign data_movement_mode          = mode_q.dmm;
  assign calculation_pattern_mode    = mode_q.cpm;
  assign enable_right_angle_movement = drain_q;
  assign drain_valid                 = drain_q;
  assign store_stationary            = store_q;
  assign feed_req                    = feed_q;
  assign busy                        = busy_q;
  assign done                        = done_q;
  assign err_underrun                = err_und_q;
  assign err_cmd                     = err_cmd_q;

endmodule

// File: tb/tb_redas_dataflow_controller.sv
// Directed and randomized bench for redas_dataflow_controller against a
// phase-timeline reference model.
module tb_redas_dataflow_controller;

  localparam int unsigned D  = 4;
  localparam int unsigned KW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dataflow;
  logic [KW-1:0] cmd_k_len;
  logic          abort;
  logic          feed_valid;
  logic [3:0]    data_movement_mode;
  logic [4:0]    calculation_pattern_mode;
  logic          enable_right_angle_movement;
  logic          store_stationary;
  logic          feed_req;
  logic          drain_valid;
  logic          busy;
  logic          done;
  logic          err_underrun;
  logic          err_cmd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  redas_dataflow_controller #(.ARRAY_DIM(D), .K_WIDTH(KW)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .cmd_valid                   (cmd_valid),
    .cmd_ready                   (cmd_ready),
    .cmd_dataflow                (cmd_dataflow),
    .cmd_k_len                   (cmd_k_len),
    .abort                       (abort),
    .feed_valid                  (feed_valid),
    .data_movement_mode          (data_movement_mode),
    .calculation_pattern_mode    (calculation_pattern_mode),
    .enable_right_angle_movement (enable_right_angle_movement),
    .store_stationary            (store_stationary),
    .feed_req                    (feed_req),
    .drain_valid                 (drain_valid),
    .busy                        (busy),
    .done                        (done),
    .err_underrun                (err_underrun),
    .err_cmd                     (err_cmd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_mode(input int df, input bit legal);
    logic [8:0] m;
    m = 9'b1111_11000;
    if (legal) begin
      case (df)
        0:       m = 9'b1111_00011;
        1:       m = 9'b0101_00101;
        default: m = 9'b1010_00111;
      endcase
    end
    return m;
  endfunction

  // Issue one command from a negedge and check every cycle until the IDLE
  // cycle that follows done (or abort). fmode: 0 feed always, 1 drop at drop_n, 2 random.
  task automatic run_cmd(input int df, input int k, input int fmode, input int drop_n,
                         input int abort_n, input bit hold, input bit abort_acc);
    bit         legal;
    int         pre, comp, dr, tot, last, idx;
    bit         und, fv, e_feed, e_store, e_drain;
    logic [8:0] e_mode;
    logic [6:0] e_bits;

    legal  = (df != 3) && (k != 0);
    pre    = (legal && df != 1) ? int'(D) : 0;
    comp   = legal ? k + 2 * int'(D) - 2 : 0;
    dr     = (legal && df == 1) ? int'(D) : 0;
    tot    = 2 + pre + comp + dr;
    last   = (abort_n > 0) ? abort_n + 1 : tot + 1;
    und    = 1'b0;
    e_mode = exp_mode(df, legal);

    cmd_valid    = 1'b1;
    cmd_dataflow = 2'(df);
    cmd_k_len    = KW'(k);
    abort        = abort_acc;
    chk("ready_at_offer", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;

    for (int n = 1; n <= last; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      case (fmode)
        0:       fv = 1'b1;
        1:       fv = (n != drop_n);
        default: fv = ($urandom_range(0, 5) != 0);
      endcase
      feed_valid = fv;
      abort      = (n == abort_n);
      @(negedge clk);
      if (n == last) begin
        chk("idle_mode", 32'({data_movement_mode, calculation_pattern_mode}), 32'(9'b1111_11000));
        chk("idle_ctrl", 32'({cmd_ready, busy, done, feed_req, store_stationary,
                              enable_right_angle_movement, drain_valid}), 32'(7'b1000000));
        if (abort_n == 0) begin
          chk("idle_err_cmd", 32'(err_cmd), 32'(!legal));
          chk("idle_err_und", 32'(err_underrun), 32'(und));
        end
      end else begin
        e_feed  = 1'b0;
        e_store = 1'b0;
        e_drain = 1'b0;
        if (n > 1 && n <= 1 + pre) begin
          e_feed  = 1'b1;
          e_store = 1'b1;
        end else if (n > 1 + pre && n <= 1 + pre + comp) begin
          idx     = n - 2 - pre;
          e_feed  = (idx < k);
          e_store = (df == 1);
        end else if (n > 1 + pre + comp && n < tot) begin
          e_drain = 1'b1;
        end
        e_bits = {1'b0, 1'b1, (n == tot), e_feed, e_store, e_drain, e_drain};
        chk("run_mode", 32'({data_movement_mode, calculation_pattern_mode}), 32'(e_mode));
        chk("run_ctrl", 32'({cmd_ready, busy, done, feed_req, store_stationary,
                             enable_right_angle_movement, drain_valid}), 32'(e_bits));
        chk("run_err_cmd", 32'(err_cmd), 32'(!legal));
        chk("run_err_und", 32'(err_underrun), 32'(und));
        und = und | (e_feed & ~fv);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_dataflow = 2'd0;
    cmd_k_len    = '0;
    abort        = 1'b0;
    feed_valid   = 1'b1;

    @(negedge clk);
    chk("rst_mode", 32'({data_movement_mode, calculation_pattern_mode}), 32'(9'b1111_11000));
    chk("rst_bits", 32'({cmd_ready, busy, done, feed_req, store_stationary,
                         enable_right_angle_movement, drain_valid, err_underrun, err_cmd}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_mode", 32'({data_movement_mode, calculation_pattern_mode}), 32'(9'b1111_11000));

    // Weight, output and input stationary directed runs
    run_cmd(0, 10, 0, 0, 0, 1'b0, 1'b0);
    run_cmd(1, 3, 0, 0, 0, 1'b0, 1'b0);
    run_cmd(2, 5, 1, 8, 0, 1'b0, 1'b0);
    run_cmd(0, 2, 0, 0, 0, 1'b0, 1'b0);

    // Illegal commands
    run_cmd(3, 4, 0, 0, 0, 1'b0, 1'b0);
    run_cmd(0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Abort in COMPUTE cycle 3; abort coincident with acceptance in IDLE
    run_cmd(0, 6, 0, 0, 2 + int'(D) + 2, 1'b0, 1'b0);
    run_cmd(1, 2, 0, 0, 0, 1'b0, 1'b1);

    // Largest k: COMPUTE length must not wrap
    run_cmd(2, 255, 0, 0, 0, 1'b0, 1'b0);

    // Back-to-back with cmd_valid held high
    run_cmd(0, 3, 0, 0, 0, 1'b1, 1'b0);
    run_cmd(0, 2, 0, 0, 0, 1'b0, 1'b0);

    // Reset mid-PRELOAD after an underrun
    cmd_valid    = 1'b1;
    cmd_dataflow = 2'd0;
    cmd_k_len    = KW'(5);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    feed_valid = 1'b1;
    @(posedge clk);
    #1;
    feed_valid = 1'b0;
    @(posedge clk);
    #1;
    feed_valid = 1'b1;
    #2;
    chk("pre_rst_und", 32'(err_underrun), 32'd1);
    chk("pre_rst_store", 32'(store_stationary), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mode", 32'({data_movement_mode, calculation_pattern_mode}), 32'(9'b1111_11000));
    chk("async_rst_bits", 32'({busy, done, feed_req, store_stationary,
                               enable_right_angle_movement, drain_valid, err_underrun, err_cmd}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(cmd_ready), 32'd1);
    chk("rst_release_busy", 32'(busy), 32'd0);

    // Randomized commands with random feeder gaps
    for (int i = 0; i < 8; i++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 2, 0, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
